gpr_file: RTL and testbench

General-purpose register file serving the decode stage's two register read requests, plus the write-back stage's single write port. It is the responder for the decode stage's `reg1_read_o/reg1_addr_o` and `reg2_read_o/reg2_addr_o` requests, and returns `reg1_data_i/reg2_data_i` in the same cycle. After reset it runs a sequential clear of the array, because the storage itself has no reset. It also provides a registered debug read port with a request/acknowledge handshake.

---
 rtl/gpr_file.sv | 103 ++++++++++
 tb/tb_gpr_file.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gpr_file.sv
// General-purpose register file: two combinational read ports with write-through
// bypass, one write port, post-reset sequential clear, and a registered debug read port.
module gpr_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic              init_done_o,
   input  logic              dbg_req_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic              dbg_ack_o,
   output logic [DATA_W-1:0] dbg_data_o
);

   localparam int NREG = 2 ** ADDR_W;

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] clr_idx, clr_idx_n;
   logic              ready;
   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] dbg_next;

   assign ready       = (state == READY);
   assign init_done_o = ready;

   // Zero rules first, then same-cycle write bypass, then the stored value.
   function automatic logic [DATA_W-1:0] resolve(
      input logic              en,
      input logic [ADDR_W-1:0] a,
      input logic [DATA_W-1:0] stored,
      input logic              live,
      input logic              wr,
      input logic [ADDR_W-1:0] wa,
      input logic [DATA_W-1:0] wd
   );
      logic [DATA_W-1:0] v;
      v = '0;
      if (live && (a != '0) && en) begin
         if (wr && (a == wa))
            v = wd;
         else
            v = stored;
      end
      return v;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= ADDR_W'(1);
      end else begin
         state   <= state_n;
         clr_idx <= clr_idx_n;
      end
   end

   always_comb begin
      state_n   = state;
      clr_idx_n = clr_idx;
      if (state == CLEAR) begin
         clr_idx_n = clr_idx + ADDR_W'(1);
         if (clr_idx == '1)
            state_n = READY;
      end
   end

   // Storage carries no reset; the CLEAR walk zeroes indices 1..NREG-1 instead.
   always_ff @(posedge clk) begin
      if (state == CLEAR)
         regs[clr_idx] <= '0;
      else if (we && (waddr != '0))
         regs[waddr] <= wdata;
   end

   assign rdata1   = resolve(re1, raddr1, regs[raddr1], ready & ~rst, we, waddr, wdata);
   assign rdata2   = resolve(re2, raddr2, regs[raddr2], ready & ~rst, we, waddr, wdata);
   assign dbg_next = resolve(1'b1, dbg_addr_i, regs[dbg_addr_i], ready, we, waddr, wdata);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_ack_o  <= 1'b0;
         dbg_data_o <= '0;
      end else if (ready && dbg_req_i) begin
         dbg_ack_o  <= 1'b1;
         dbg_data_o <= dbg_next;
      end else begin
         dbg_ack_o  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gpr_file.sv
// Randomized bench for gpr_file, checked against an array-based reference model.
module tb_gpr_file;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          re1, re2;
   logic [AW-1:0] raddr1, raddr2;
   logic [DW-1:0] rdata1, rdata2;
   logic          init_done_o;
   logic          dbg_req_i;
   logic [AW-1:0] dbg_addr_i;
   logic          dbg_ack_o;
   logic [DW-1:0] dbg_data_o;

   always #5 clk = ~clk;

   gpr_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .re1        (re1),
      .raddr1     (raddr1),
      .rdata1     (rdata1),
      .re2        (re2),
      .raddr2     (raddr2),
      .rdata2     (rdata2),
      .init_done_o(init_done_o),
      .dbg_req_i  (dbg_req_i),
      .dbg_addr_i (dbg_addr_i),
      .dbg_ack_o  (dbg_ack_o),
      .dbg_data_o (dbg_data_o)
   );

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   // Reference model: register contents, clear progress, debug output state.
   logic [DW-1:0] mdl [NREG];
   bit            mdl_ready;
   int unsigned   clr_edges;
   logic          mdl_ack;
   logic [DW-1:0] mdl_dbg;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_read(input logic en, input logic [AW-1:0] a);
      if (rst || !mdl_ready || a == '0) return '0;
      if (en && we && a == waddr) return wdata;
      if (en) return mdl[a];
      return '0;
   endfunction

   task automatic apply_reset();
      rst       = 1'b1;
      mdl_ready = 1'b0;
      clr_edges = 0;
      mdl_ack   = 1'b0;
      mdl_dbg   = '0;
   endtask

   // Inputs are already set; check mid-cycle, then advance the model at the edge.
   task automatic cycle();
      @(negedge clk);
      chk("rdata1", rdata1, exp_read(re1, raddr1));
      chk("rdata2", rdata2, exp_read(re2, raddr2));
      chk("init_done", DW'(init_done_o), DW'(mdl_ready));
      chk("dbg_ack", DW'(dbg_ack_o), DW'(mdl_ack));
      chk("dbg_data", dbg_data_o, mdl_dbg);
      @(posedge clk);
      if (!rst) begin
         if (mdl_ready) begin
            if (dbg_req_i) begin
               mdl_ack = 1'b1;
               mdl_dbg = exp_read(1'b1, dbg_addr_i);
            end else begin
               mdl_ack = 1'b0;
            end
            if (we && waddr != '0) mdl[waddr] = wdata;
         end else begin
            mdl_ack = 1'b0;
            clr_edges++;
            if (clr_edges == NREG - 1) begin
               mdl_ready = 1'b1;
               foreach (mdl[i]) mdl[i] = '0;
            end
         end
      end
      #1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, 3));
      return AW'($urandom);
   endfunction

   initial begin
      we = 0; waddr = '0; wdata = '0;
      re1 = 0; raddr1 = '0; re2 = 0; raddr2 = '0;
      dbg_req_i = 0; dbg_addr_i = '0;
      foreach (mdl[i]) mdl[i] = '0;
      apply_reset();
      repeat (2) cycle();
      rst = 1'b0;

      // Debug request pending and a write at edge 4, both during the clear walk
      dbg_req_i  = 1'b1;
      dbg_addr_i = 5'd3;
      for (int i = 0; i < 40; i++) begin
         we     = (i == 3);
         waddr  = 5'd3;
         wdata  = 32'h55;
         re1    = 1'b1;
         raddr1 = 5'd3;
         re2    = 1'b1;
         raddr2 = AW'(i);
         cycle();
      end
      dbg_req_i = 1'b0;
      we        = 1'b0;

      // Reset reasserted at edge 10 of the clear
      apply_reset(); cycle(); rst = 1'b0;
      repeat (10) cycle();
      apply_reset(); cycle(); rst = 1'b0;
      repeat (35) cycle();

      // Write then read
      we = 1; waddr = 5'd5; wdata = 32'h1234ABCD; re1 = 0; re2 = 0;
      cycle();
      we = 0; re1 = 1; raddr1 = 5'd5; re2 = 0; raddr2 = 5'd5;
      cycle();

      // Same-cycle bypass on both ports
      we = 1; waddr = 5'd7; wdata = 32'hDEADBEEF;
      re1 = 1; re2 = 1; raddr1 = 5'd7; raddr2 = 5'd7;
      cycle();
      we = 0;
      cycle();

      // Register 0 including its bypass cycle and a debug read
      we = 1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
      dbg_req_i = 1; dbg_addr_i = 5'd0;
      cycle();
      we = 0; dbg_req_i = 0;
      repeat (2) cycle();

      // Single-cycle debug request
      we = 1; waddr = 5'd9; wdata = 32'hCAFEF00D;
      cycle();
      we = 0; dbg_req_i = 1; dbg_addr_i = 5'd9;
      cycle();
      dbg_req_i = 0;
      repeat (2) cycle();

      // Three back-to-back debug acks
      dbg_req_i = 1; dbg_addr_i = 5'd5;
      repeat (3) cycle();
      dbg_req_i = 0;
      repeat (2) cycle();

      for (int n = 0; n < 3000; n++) begin
         we         = ($urandom_range(0, 1) == 1);
         waddr      = rnd_addr();
         wdata      = $urandom;
         re1        = ($urandom_range(0, 3) != 0);
         raddr1     = rnd_addr();
         re2        = ($urandom_range(0, 3) != 0);
         raddr2     = rnd_addr();
         dbg_req_i  = ($urandom_range(0, 2) == 0);
         dbg_addr_i = rnd_addr();
         if ($urandom_range(0, 499) == 0) begin
            apply_reset();
            cycle();
            rst = 1'b0;
         end else begin
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
